// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 scan-code constants and ASCII helper values for the
// keyboard decode path.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] ASCII_NONE = 8'h00;

    localparam logic [7:0] KC_A = 8'h1C, KC_B = 8'h32, KC_C = 8'h21, KC_D = 8'h23;
    localparam logic [7:0] KC_E = 8'h24, KC_F = 8'h2B, KC_G = 8'h34, KC_H = 8'h33;
    localparam logic [7:0] KC_I = 8'h43, KC_J = 8'h3B, KC_K = 8'h42, KC_L = 8'h4B;
    localparam logic [7:0] KC_M = 8'h3A, KC_N = 8'h31, KC_O = 8'h44, KC_P = 8'h4D;
    localparam logic [7:0] KC_Q = 8'h15, KC_R = 8'h2D, KC_S = 8'h1B, KC_T = 8'h2C;
    localparam logic [7:0] KC_U = 8'h3C, KC_V = 8'h2A, KC_W = 8'h1D, KC_X = 8'h22;
    localparam logic [7:0] KC_Y = 8'h35, KC_Z = 8'h1A;

    localparam logic [7:0] KC_0 = 8'h45, KC_1 = 8'h16, KC_2 = 8'h1E, KC_3 = 8'h26;
    localparam logic [7:0] KC_4 = 8'h25, KC_5 = 8'h2E, KC_6 = 8'h36, KC_7 = 8'h3D;
    localparam logic [7:0] KC_8 = 8'h3E, KC_9 = 8'h46;

    localparam logic [7:0] KC_BACKTICK  = 8'h0E, KC_MINUS    = 8'h4E, KC_EQUAL  = 8'h55;
    localparam logic [7:0] KC_LBRACKET  = 8'h54, KC_RBRACKET = 8'h5B, KC_BSLASH = 8'h5D;
    localparam logic [7:0] KC_SEMICOLON = 8'h4C, KC_QUOTE    = 8'h52, KC_COMMA  = 8'h41;
    localparam logic [7:0] KC_PERIOD    = 8'h49, KC_SLASH    = 8'h4A;

    localparam logic [7:0] KC_SPACE = 8'h29, KC_ENTER = 8'h5A, KC_BKSP = 8'h66;
    localparam logic [7:0] KC_TAB   = 8'h0D, KC_ESC   = 8'h76;

endpackage

// File: rtl/ps2_scancode_ascii_rom.sv
// Set-2 make code to ASCII lookup with a single registered output stage.
// Unmapped codes, prefixes and idle (0x00) all produce 0x00.
module ps2_scancode_ascii_rom
    import ps2_pkg::*;
#(
    parameter bit LOWERCASE = 1'b1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] scancode,
    output logic [7:0] ascii
);

    localparam logic [7:0] LETTER_BASE = LOWERCASE ? 8'h61 : 8'h41;

    logic [7:0] ascii_d;
    logic [7:0] ascii_q;

    always_comb begin
        ascii_d = ASCII_NONE;
        case (scancode)
            KC_A: ascii_d = LETTER_BASE + 8'd0;
            KC_B: ascii_d = LETTER_BASE + 8'd1;
            KC_C: ascii_d = LETTER_BASE + 8'd2;
            KC_D: ascii_d = LETTER_BASE + 8'd3;
            KC_E: ascii_d = LETTER_BASE + 8'd4;
            KC_F: ascii_d = LETTER_BASE + 8'd5;
            KC_G: ascii_d = LETTER_BASE + 8'd6;
            KC_H: ascii_d = LETTER_BASE + 8'd7;
            KC_I: ascii_d = LETTER_BASE + 8'd8;
            KC_J: ascii_d = LETTER_BASE + 8'd9;
            KC_K: ascii_d = LETTER_BASE + 8'd10;
            KC_L: ascii_d = LETTER_BASE + 8'd11;
            KC_M: ascii_d = LETTER_BASE + 8'd12;
            KC_N: ascii_d = LETTER_BASE + 8'd13;
            KC_O: ascii_d = LETTER_BASE + 8'd14;
            KC_P: ascii_d = LETTER_BASE + 8'd15;
            KC_Q: ascii_d = LETTER_BASE + 8'd16;
            KC_R: ascii_d = LETTER_BASE + 8'd17;
            KC_S: ascii_d = LETTER_BASE + 8'd18;
            KC_T: ascii_d = LETTER_BASE + 8'd19;
            KC_U: ascii_d = LETTER_BASE + 8'd20;
            KC_V: ascii_d = LETTER_BASE + 8'd21;
            KC_W: ascii_d = LETTER_BASE + 8'd22;
            KC_X: ascii_d = LETTER_BASE + 8'd23;
            KC_Y: ascii_d = LETTER_BASE + 8'd24;
            KC_Z: ascii_d = LETTER_BASE + 8'd25;
            KC_0: ascii_d = 8'h30;
            KC_1: ascii_d = 8'h31;
            KC_2: ascii_d = 8'h32;
            KC_3: ascii_d = 8'h33;
            KC_4: ascii_d = 8'h34;
            KC_5: ascii_d = 8'h35;
            KC_6: ascii_d = 8'h36;
            KC_7: ascii_d = 8'h37;
            KC_8: ascii_d = 8'h38;
            KC_9: ascii_d = 8'h39;
            KC_BACKTICK:  ascii_d = 8'h60;
            KC_MINUS:     ascii_d = 8'h2D;
            KC_EQUAL:     ascii_d = 8'h3D;
            KC_LBRACKET:  ascii_d = 8'h5B;
            KC_RBRACKET:  ascii_d = 8'h5D;
            KC_BSLASH:    ascii_d = 8'h5C;
            KC_SEMICOLON: ascii_d = 8'h3B;
            KC_QUOTE:     ascii_d = 8'h27;
            KC_COMMA:     ascii_d = 8'h2C;
            KC_PERIOD:    ascii_d = 8'h2E;
            KC_SLASH:     ascii_d = 8'h2F;
            KC_SPACE: ascii_d = 8'h20;
            KC_ENTER: ascii_d = 8'h0D;
            KC_BKSP:  ascii_d = 8'h08;
            KC_TAB:   ascii_d = 8'h09;
            KC_ESC:   ascii_d = 8'h1B;
            // Break/extended prefixes fall through to ASCII_NONE.
            default:  ascii_d = ASCII_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ascii_q <= ASCII_NONE;
        end else begin
            ascii_q <= ascii_d;
        end
    end

    assign ascii = ascii_q;

endmodule

// File: tb/tb_ps2_scancode_ascii_rom.sv
// Directed bench for the scan-code ROM: reset, letters in both cases,
// digits/control, back-to-back latency, prefixes and a full 0x00..0xFF sweep.
module tb_ps2_scancode_ascii_rom;

    logic       clk;
    logic       clrn;
    logic [7:0] scancode;
    logic [7:0] ascii_lc;
    logic [7:0] ascii_uc;

    int checks;
    int errors;

    ps2_scancode_ascii_rom #(.LOWERCASE(1'b1)) dut_lc (
        .clk      (clk),
        .clrn     (clrn),
        .scancode (scancode),
        .ascii    (ascii_lc)
    );

    ps2_scancode_ascii_rom #(.LOWERCASE(1'b0)) dut_uc (
        .clk      (clk),
        .clrn     (clrn),
        .scancode (scancode),
        .ascii    (ascii_uc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tables typed straight from the Set-2 key chart.
    logic [7:0] letter_codes [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] misc_codes [16] = '{
        8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A,
        8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [7:0] misc_chars [16] = '{
        8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F,
        8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

    function automatic logic [7:0] model(input logic [7:0] code, input bit lower);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) r = (lower ? 8'h61 : 8'h41) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == code) r = 8'h30 + 8'(i);
        for (int i = 0; i < 16; i++)
            if (misc_codes[i] == code) r = misc_chars[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Drive a code after a falling edge, then sample after the next rising edge.
    task automatic step(input logic [7:0] code);
        @(negedge clk);
        scancode = code;
        @(negedge clk);
    endtask

    task automatic step_check(input string tag, input logic [7:0] code,
                              input logic [7:0] exp_lc, input logic [7:0] exp_uc);
        step(code);
        check({tag, "_lc"}, ascii_lc, exp_lc);
        check({tag, "_uc"}, ascii_uc, exp_uc);
        $display("code 0x%02h -> lc 0x%02h uc 0x%02h", code, ascii_lc, ascii_uc);
    endtask

    logic [7:0] bad_codes [5] = '{8'hF0, 8'hE0, 8'h00, 8'hFF, 8'h83};

    initial begin
        checks   = 0;
        errors   = 0;
        clrn     = 1'b0;
        scancode = 8'h1C;

        // Reset asserted with a live code: output held at zero across edges.
        #1;
        check("reset_immediate", ascii_lc, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held_lc", ascii_lc, 8'h00);
        check("reset_held_uc", ascii_uc, 8'h00);

        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check("release_lc", ascii_lc, 8'h61);
        check("release_uc", ascii_uc, 8'h41);

        // Letters
        step_check("letter_a", 8'h1C, 8'h61, 8'h41);
        step_check("letter_z", 8'h1A, 8'h7A, 8'h5A);
        step_check("letter_q", 8'h15, 8'h71, 8'h51);

        // Digits and control
        step_check("digit_0",   8'h45, 8'h30, 8'h30);
        step_check("digit_9",   8'h46, 8'h39, 8'h39);
        step_check("space",     8'h29, 8'h20, 8'h20);
        step_check("enter",     8'h5A, 8'h0D, 8'h0D);
        step_check("backspace", 8'h66, 8'h08, 8'h08);

        // Back-to-back codes: one result per cycle, one-edge latency.
        @(negedge clk);
        scancode = 8'h16;
        @(negedge clk);
        check("latency_1", ascii_lc, 8'h31);
        scancode = 8'h1E;
        @(negedge clk);
        check("latency_2", ascii_lc, 8'h32);
        $display("latency pair 0x16,0x1E -> 0x31,0x32 observed 0x%02h", ascii_lc);

        // Prefix and unmapped codes
        for (int i = 0; i < 5; i++)
            step_check("unmapped", bad_codes[i], 8'h00, 8'h00);

        // Asynchronous clear mid-stream, away from any edge.
        step(8'h1C);
        #2;
        clrn = 1'b0;
        #1;
        check("async_clear_lc", ascii_lc, 8'h00);
        check("async_clear_uc", ascii_uc, 8'h00);
        @(negedge clk);
        check("async_hold", ascii_lc, 8'h00);
        scancode = 8'h1A;
        clrn = 1'b1;
        @(negedge clk);
        check("async_release", ascii_lc, 8'h7A);
        $display("reset mid-stream then 0x1A -> 0x%02h", ascii_lc);

        // Exhaustive sweep of every code against the reference tables.
        for (int c = 0; c < 256; c++) begin
            step(8'(c));
            check("sweep_lc", ascii_lc, model(8'(c), 1'b1));
            check("sweep_uc", ascii_uc, model(8'(c), 1'b0));
            $display("sweep 0x%02h -> lc 0x%02h uc 0x%02h", c[7:0], ascii_lc, ascii_uc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
